// File: rtl/v_pipe_query_rsp.sv
// rtl/v_pipe_query_rsp.sv - tagged key/value lookup responder; optional hit/miss counters under V_PIPE_QUERY_RSP_STATS_EN
module v_pipe_query_rsp #(
    parameter int N_ENTRIES = 8,
    parameter int KEY_W     = 16,
    parameter int VAL_W     = 32,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             qry_vld,
    output logic             qry_rdy,
    input  logic [KEY_W-1:0] qry_key,
    input  logic [TAG_W-1:0] qry_tag,
    input  logic             upd_vld,
    input  logic             upd_del,
    input  logic [KEY_W-1:0] upd_key,
    input  logic [VAL_W-1:0] upd_val,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_hit,
    output logic [VAL_W-1:0] rsp_val
`ifdef V_PIPE_QUERY_RSP_STATS_EN
    ,
    output logic [31:0]      stat_hit_cnt,
    output logic [31:0]      stat_miss_cnt
`endif
);
    localparam int IDX_W = $clog2(N_ENTRIES);

    // Key/value table
    logic [N_ENTRIES-1:0] tbl_vld_q, tbl_vld_d;
    logic [KEY_W-1:0]     tbl_key_q [N_ENTRIES];
    logic [KEY_W-1:0]     tbl_key_d [N_ENTRIES];
    logic [VAL_W-1:0]     tbl_val_q [N_ENTRIES];
    logic [VAL_W-1:0]     tbl_val_d [N_ENTRIES];
    logic [IDX_W-1:0]     victim_q, victim_d;

    // Compare stage
    logic                 s1_vld_q, s1_vld_d;
    logic [KEY_W-1:0]     s1_key_q, s1_key_d;
    logic [TAG_W-1:0]     s1_tag_q, s1_tag_d;

    // Two-entry result FIFO
    logic [TAG_W-1:0]     fifo_tag_q [2];
    logic [TAG_W-1:0]     fifo_tag_d [2];
    logic                 fifo_hit_q [2];
    logic                 fifo_hit_d [2];
    logic [VAL_W-1:0]     fifo_val_q [2];
    logic [VAL_W-1:0]     fifo_val_d [2];
    logic                 fifo_wr_q, fifo_wr_d;
    logic                 fifo_rd_q, fifo_rd_d;
    logic [1:0]           fifo_cnt_q, fifo_cnt_d;

    logic                 qry_acc;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 lk_hit;
    logic [VAL_W-1:0]     lk_val;
    logic                 upd_match;
    logic [IDX_W-1:0]     upd_idx;
    logic                 free_any;
    logic [IDX_W-1:0]     free_idx;

`ifdef V_PIPE_QUERY_RSP_STATS_EN
    logic [31:0]          stat_hit_cnt_q, stat_hit_cnt_d;
    logic [31:0]          stat_miss_cnt_q, stat_miss_cnt_d;
`endif

    // Ready depends only on held state so the issuer never sees a path from rsp_rdy.
    assign qry_rdy   = !(s1_vld_q && (fifo_cnt_q == 2'd2));
    assign qry_acc   = qry_vld && qry_rdy;
    assign rsp_vld   = (fifo_cnt_q != 2'd0);
    assign fifo_pop  = rsp_vld && rsp_rdy;
    assign fifo_push = s1_vld_q && ((fifo_cnt_q != 2'd2) || fifo_pop);
    assign rsp_tag   = fifo_tag_q[fifo_rd_q];
    assign rsp_hit   = fifo_hit_q[fifo_rd_q];
    assign rsp_val   = fifo_val_q[fifo_rd_q];

    // Parallel compare of the S1 key against the pre-update table; at most one entry matches.
    always_comb begin
        lk_hit = 1'b0;
        lk_val = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (tbl_vld_q[i] && (tbl_key_q[i] == s1_key_q)) begin
                lk_hit = 1'b1;
                lk_val = lk_val | tbl_val_q[i];
            end
        end
    end

    // Locate the update key's entry and the lowest-index free entry.
    always_comb begin
        upd_match = 1'b0;
        upd_idx   = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (tbl_vld_q[i] && (tbl_key_q[i] == upd_key)) begin
                upd_match = 1'b1;
                upd_idx   = IDX_W'(i);
            end
        end
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!tbl_vld_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Table maintenance: delete, overwrite, allocate free, or replace round-robin victim.
    always_comb begin
        tbl_vld_d = tbl_vld_q;
        tbl_key_d = tbl_key_q;
        tbl_val_d = tbl_val_q;
        victim_d  = victim_q;
        if (upd_vld) begin
            if (upd_del) begin
                if (upd_match) begin
                    tbl_vld_d[upd_idx] = 1'b0;
                end
            end else if (upd_match) begin
                tbl_val_d[upd_idx] = upd_val;
            end else if (free_any) begin
                tbl_vld_d[free_idx] = 1'b1;
                tbl_key_d[free_idx] = upd_key;
                tbl_val_d[free_idx] = upd_val;
            end else begin
                tbl_key_d[victim_q] = upd_key;
                tbl_val_d[victim_q] = upd_val;
                victim_d            = victim_q + IDX_W'(1);
            end
        end
    end

    // S1 loads on an accepted query and empties once its result has been pushed.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_key_d = s1_key_q;
        s1_tag_d = s1_tag_q;
        if (qry_acc) begin
            s1_vld_d = 1'b1;
            s1_key_d = qry_key;
            s1_tag_d = qry_tag;
        end else if (fifo_push) begin
            s1_vld_d = 1'b0;
        end
    end

    // Result FIFO push/pop bookkeeping; a miss stores value 0.
    always_comb begin
        fifo_tag_d = fifo_tag_q;
        fifo_hit_d = fifo_hit_q;
        fifo_val_d = fifo_val_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        if (fifo_push) begin
            fifo_tag_d[fifo_wr_q] = s1_tag_q;
            fifo_hit_d[fifo_wr_q] = lk_hit;
            fifo_val_d[fifo_wr_q] = lk_hit ? lk_val : '0;
            fifo_wr_d             = ~fifo_wr_q;
        end
        if (fifo_pop) begin
            fifo_rd_d = ~fifo_rd_q;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end

`ifdef V_PIPE_QUERY_RSP_STATS_EN
    // Saturating hit/miss counters, counted at FIFO push.
    always_comb begin
        stat_hit_cnt_d  = stat_hit_cnt_q;
        stat_miss_cnt_d = stat_miss_cnt_q;
        if (fifo_push && lk_hit && (stat_hit_cnt_q != 32'hFFFF_FFFF)) begin
            stat_hit_cnt_d = stat_hit_cnt_q + 32'd1;
        end
        if (fifo_push && !lk_hit && (stat_miss_cnt_q != 32'hFFFF_FFFF)) begin
            stat_miss_cnt_d = stat_miss_cnt_q + 32'd1;
        end
    end

    assign stat_hit_cnt  = stat_hit_cnt_q;
    assign stat_miss_cnt = stat_miss_cnt_q;
`endif

    // State registers; reset drops in-flight queries and results.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_vld_q  <= '0;
            victim_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_key_q   <= '0;
            s1_tag_q   <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                tbl_key_q[i] <= '0;
                tbl_val_q[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                fifo_tag_q[i] <= '0;
                fifo_hit_q[i] <= 1'b0;
                fifo_val_q[i] <= '0;
            end
`ifdef V_PIPE_QUERY_RSP_STATS_EN
            stat_hit_cnt_q  <= '0;
            stat_miss_cnt_q <= '0;
`endif
        end else begin
            tbl_vld_q  <= tbl_vld_d;
            tbl_key_q  <= tbl_key_d;
            tbl_val_q  <= tbl_val_d;
            victim_q   <= victim_d;
            s1_vld_q   <= s1_vld_d;
            s1_key_q   <= s1_key_d;
            s1_tag_q   <= s1_tag_d;
            fifo_tag_q <= fifo_tag_d;
            fifo_hit_q <= fifo_hit_d;
            fifo_val_q <= fifo_val_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
`ifdef V_PIPE_QUERY_RSP_STATS_EN
            stat_hit_cnt_q  <= stat_hit_cnt_d;
            stat_miss_cnt_q <= stat_miss_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_v_pipe_query_rsp.sv
// tb/tb_v_pipe_query_rsp.sv - scoreboard bench for v_pipe_query_rsp
module tb_v_pipe_query_rsp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        qry_vld = 1'b0;
    logic        qry_rdy;
    logic [15:0] qry_key = '0;
    logic [3:0]  qry_tag = '0;
    logic        upd_vld = 1'b0;
    logic        upd_del = 1'b0;
    logic [15:0] upd_key = '0;
    logic [31:0] upd_val = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic [3:0]  rsp_tag;
    logic        rsp_hit;
    logic [31:0] rsp_val;
`ifdef V_PIPE_QUERY_RSP_STATS_EN
    logic [31:0] stat_hit_cnt;
    logic [31:0] stat_miss_cnt;
`endif

    v_pipe_query_rsp dut (
        .clk(clk), .rst(rst),
        .qry_vld(qry_vld), .qry_rdy(qry_rdy), .qry_key(qry_key), .qry_tag(qry_tag),
        .upd_vld(upd_vld), .upd_del(upd_del), .upd_key(upd_key), .upd_val(upd_val),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_tag(rsp_tag), .rsp_hit(rsp_hit),
        .rsp_val(rsp_val)
`ifdef V_PIPE_QUERY_RSP_STATS_EN
        , .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rsp = 0;
    bit last_acc = 1'b0;

    // Reference model: associative table described by its replacement rules.
    bit          m_vld [8];
    logic [15:0] m_key [8];
    logic [31:0] m_val [8];
    int          m_victim = 0;
    bit          pend = 1'b0;
    logic [15:0] pend_key;
    logic [3:0]  pend_tag;
    logic [36:0] exp_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_edge(bit r, bit acc, logic [15:0] k, logic [3:0] t,
                                       bit uv, bit ud, logic [15:0] uk, logic [31:0] uval);
        int idx;
        int free;
        bit hit;
        logic [31:0] v;
        if (r) begin
            foreach (m_vld[i]) m_vld[i] = 1'b0;
            m_victim = 0;
            pend = 1'b0;
            exp_q.delete();
            return;
        end
        if (pend) begin
            hit = 1'b0;
            v = 32'd0;
            foreach (m_vld[i]) if (m_vld[i] && m_key[i] == pend_key) begin hit = 1'b1; v = m_val[i]; end
            exp_q.push_back({pend_tag, hit, v});
        end
        if (uv) begin
            idx = -1;
            free = -1;
            foreach (m_vld[i]) if (m_vld[i] && m_key[i] == uk) idx = i;
            for (int i = 7; i >= 0; i--) if (!m_vld[i]) free = i;
            if (ud) begin
                if (idx >= 0) m_vld[idx] = 1'b0;
            end else if (idx >= 0) begin
                m_val[idx] = uval;
            end else if (free >= 0) begin
                m_vld[free] = 1'b1; m_key[free] = uk; m_val[free] = uval;
            end else begin
                m_key[m_victim] = uk; m_val[m_victim] = uval;
                m_victim = (m_victim + 1) % 8;
            end
        end
        pend = acc;
        pend_key = k;
        pend_tag = t;
    endfunction

    // One clock: sample handshake mid-cycle, advance model at the edge, return #1 after it.
    task automatic cyc();
        bit acc;
        @(negedge clk);
        acc = qry_vld && qry_rdy;
        @(posedge clk);
        model_edge(rst, acc, qry_key, qry_tag, upd_vld, upd_del, upd_key, upd_val);
        last_acc = acc;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; qry_vld = 1'b0; upd_vld = 1'b0; rsp_rdy = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic upd(input bit del, input logic [15:0] k, input logic [31:0] v);
        upd_vld = 1'b1; upd_del = del; upd_key = k; upd_val = v;
        cyc();
        upd_vld = 1'b0;
    endtask

    task automatic query(input logic [15:0] k, input logic [3:0] t);
        int n;
        qry_vld = 1'b1; qry_key = k; qry_tag = t;
        n = 0;
        do begin cyc(); n++; end while (!last_acc && n < 50);
        if (!last_acc) chk("query_accept_timeout", 0, 1);
        qry_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        qry_vld = 1'b0; upd_vld = 1'b0;
        repeat (n) cyc();
    endtask

    // Monitor: pop and compare on every response handshake; check stall stability.
    initial begin
        bit          prev_stall = 1'b0;
        logic [36:0] prev;
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("rsp_stable", {rsp_vld, rsp_tag, rsp_hit, rsp_val}, {1'b1, prev});
                if (rsp_vld && rsp_rdy) begin
                    n_rsp++;
                    if (exp_q.size() == 0) chk("rsp_unexpected", {rsp_tag, rsp_hit, rsp_val}, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rsp_tag_hit_val", {rsp_tag, rsp_hit, rsp_val}, e);
                    end
                end
                prev_stall = rsp_vld && !rsp_rdy;
                prev = {rsp_tag, rsp_hit, rsp_val};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        int r0;
        logic [3:0] t;

        // Reset state
        do_reset();
        chk("reset_rsp_vld", rsp_vld, 0);
        chk("reset_qry_rdy", qry_rdy, 1);
        chk("reset_rsp_fields", {rsp_tag, rsp_hit, rsp_val}, 0);

        // 1: miss with latency 2
        rsp_rdy = 1'b1;
        qry_vld = 1'b1; qry_key = 16'h0012; qry_tag = 4'd3;
        cyc();
        qry_vld = 1'b0;
        chk("lat_t1_accept", last_acc, 1);
        chk("lat_t1_rsp_vld", rsp_vld, 0);
        cyc();
        chk("lat_t2_rsp_vld", rsp_vld, 1);
        idle(2);

        // 2: write then hit; same-cycle update vs S1 compare sees old table
        upd(1'b0, 16'h0012, 32'hDEADBEEF);
        query(16'h0012, 4'd4);
        query(16'h0055, 4'd5);
        upd(1'b0, 16'h0055, 32'h5555_0000);
        query(16'h0055, 4'd6);
        idle(3);

        // 5: delete then miss; delete of absent key is a no-op
        upd(1'b1, 16'h0012, 32'h0);
        query(16'h0012, 4'd7);
        upd(1'b1, 16'h0999, 32'h0);
        query(16'h0055, 4'd8);
        idle(3);

        // 3: fill, round-robin replacement, overwrite leaves victim alone
        do_reset();
        rsp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) upd(1'b0, 16'h0100 + 16'(i), 32'h1000 + 32'(i));
        upd(1'b0, 16'h0200, 32'hAA);
        query(16'h0100, 4'd1);
        query(16'h0200, 4'd2);
        upd(1'b0, 16'h0201, 32'hBB);
        query(16'h0101, 4'd3);
        upd(1'b0, 16'h0105, 32'd7);
        upd(1'b0, 16'h0202, 32'hCC);
        query(16'h0102, 4'd4);
        query(16'h0105, 4'd5);
        query(16'h0103, 4'd6);
        idle(3);

        // 4: backpressure fills S1 + FIFO, then in-order drain and full throughput
        rsp_rdy = 1'b0;
        acc_cnt = 0; t = 4'd9;
        qry_vld = 1'b1; qry_key = 16'h0104; qry_tag = t;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (last_acc) begin acc_cnt++; t = t + 4'd1; qry_tag = t; end
        end
        chk("stall_accept_count", acc_cnt, 3);
        chk("stall_qry_rdy", qry_rdy, 0);
        qry_vld = 1'b0;
        r0 = n_rsp;
        rsp_rdy = 1'b1;
        idle(5);
        chk("stall_drain_count", n_rsp - r0, 3);
        acc_cnt = 0;
        qry_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            qry_key = 16'h0100 + 16'(i); qry_tag = 4'(i);
            cyc();
            if (last_acc) acc_cnt++;
        end
        qry_vld = 1'b0;
        chk("throughput_accepts", acc_cnt, 8);
        idle(3);

        // 6: reset with queries in flight drops them
        rsp_rdy = 1'b0;
        qry_vld = 1'b1; qry_key = 16'h0103;
        for (int i = 0; i < 3; i++) begin qry_tag = 4'(i); cyc(); end
        do_reset();
        rsp_rdy = 1'b1;
        r0 = n_rsp;
        for (int i = 0; i < 4; i++) begin cyc(); chk("post_reset_rsp_vld", rsp_vld, 0); end
        chk("post_reset_no_rsp", n_rsp - r0, 0);

`ifdef V_PIPE_QUERY_RSP_STATS_EN
        do_reset();
        rsp_rdy = 1'b1;
        upd(1'b0, 16'h00A0, 32'd1);
        upd(1'b0, 16'h00A1, 32'd2);
        query(16'h00A0, 4'd0); query(16'h00A1, 4'd1);
        query(16'h00A0, 4'd2); query(16'h00A1, 4'd3);
        query(16'h00B0, 4'd4); query(16'h00B1, 4'd5);
        idle(4);
        chk("stat_hit_cnt", stat_hit_cnt, 4);
        chk("stat_miss_cnt", stat_miss_cnt, 2);
`endif

        // Random phase A: updates and queries with rsp_rdy held high
        rsp_rdy = 1'b1;
        for (int c = 0; c < 400; c++) begin
            qry_vld = ($urandom_range(0, 3) != 0);
            qry_key = 16'h0300 + 16'($urandom_range(0, 11));
            qry_tag = 4'($urandom);
            upd_vld = ($urandom_range(0, 2) == 0);
            upd_del = ($urandom_range(0, 3) == 0);
            upd_key = 16'h0300 + 16'($urandom_range(0, 11));
            upd_val = $urandom;
            cyc();
        end
        idle(4);

        // Random phase B: random backpressure, table static, issuer holds until accepted
        for (int c = 0; c < 300; c++) begin
            if (!qry_vld || last_acc) begin
                qry_vld = ($urandom_range(0, 2) != 0);
                qry_key = 16'h0300 + 16'($urandom_range(0, 11));
                qry_tag = 4'($urandom);
            end
            rsp_rdy = ($urandom_range(0, 1) == 1);
            cyc();
        end
        qry_vld = 1'b0;
        rsp_rdy = 1'b1;
        idle(6);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
